// File: rtl/arbitro_quadro.sv
// arbitro_quadro: runs one "apply" job on the 640x480x8 framebuffer and
// shares the framebuffer between VGA scan-out reads and CPU writes.
//   A button press latches the algorithm switches. The block then clears
//   the framebuffer, pulses the CPU start, and grants CPU writes only on
//   cycles where the VGA does not need the memory.
// Ports:
//   clock, reset (async, active-low)
//   botao_aplicar  raw active-low pushbutton (asynchronous)
//   chaves         algorithm select, latched into cpu_modo on a press
//   vga_ativo/vga_addr          VGA read request/address (always has priority)
//   cpu_wr_req/addr/data/ack    CPU write port; ack is combinational
//   cpu_done/cpu_start          CPU handshake
//   mem_addr/mem_data/mem_wren  framebuffer port (combinational mux)
//   sistema_ocupado             high while a job is in progress
//   erro                        watchdog abort flag
// Optional feature: define ARBITRO_WATCHDOG_EN to enable the EXECUTA
// watchdog. Without it, erro is tied to 0.
module arbitro_quadro #(
   parameter int unsigned       FB_WORDS    = 307200,
   parameter int unsigned       ADDR_W      = 19,
   parameter int unsigned       DATA_W      = 8,
   parameter logic [DATA_W-1:0] COR_FUNDO   = '0,
   parameter int unsigned       WDOG_CICLOS = 10000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              botao_aplicar,
   input  logic [2:0]        chaves,
   input  logic              vga_ativo,
   input  logic [ADDR_W-1:0] vga_addr,
   input  logic              cpu_wr_req,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_wr_ack,
   input  logic              cpu_done,
   output logic              cpu_start,
   output logic [2:0]        cpu_modo,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic              sistema_ocupado,
   output logic              erro
);

   localparam int unsigned       WDOG_W = 24;
   localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(FB_WORDS - 1);

   // The watchdog limit must fit in the 24-bit counter.
   if (WDOG_CICLOS < 2 || WDOG_CICLOS > (32'd1 << WDOG_W)) begin : g_wdog_chk
      $error("arbitro_quadro: WDOG_CICLOS out of range");
   end

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      LIMPA   = 2'd1,
      INICIA  = 2'd2,
      EXECUTA = 2'd3
   } estado_t;

   estado_t           state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [2:0]        modo_q, modo_d;
   logic              start_q, start_d;
   logic              ocupado_q, ocupado_d;
   logic              sync1_q, sync2_q, prev_q;
   logic              press_c;
   logic              cpu_ack_c;

`ifdef ARBITRO_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [WDOG_W-1:0] wdog_inc_c;
   logic              erro_q, erro_d;
`endif

   // Button synchronizer; flops reset to the released level (1).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= botao_aplicar;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // One pulse per press: falling edge of the synchronized button.
   assign press_c = prev_q & ~sync2_q;

   // State and job registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= OCIOSO;
         cnt_q     <= '0;
         modo_q    <= '0;
         start_q   <= 1'b0;
         ocupado_q <= 1'b0;
`ifdef ARBITRO_WATCHDOG_EN
         wdog_q    <= '0;
         erro_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         modo_q    <= modo_d;
         start_q   <= start_d;
         ocupado_q <= ocupado_d;
`ifdef ARBITRO_WATCHDOG_EN
         wdog_q    <= wdog_d;
         erro_q    <= erro_d;
`endif
      end
   end

`ifdef ARBITRO_WATCHDOG_EN
   assign wdog_inc_c = wdog_q + WDOG_W'(1);
`endif

   // Next-state logic. start and ocupado are computed from the next state
   // so that their registered values line up with state_q.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      modo_d  = modo_q;
      start_d = 1'b0;
`ifdef ARBITRO_WATCHDOG_EN
      wdog_d  = wdog_q;
      erro_d  = erro_q;
`endif
      unique case (state_q)
         OCIOSO: begin
            if (press_c) begin
               modo_d  = chaves;
               cnt_d   = '0;
               state_d = LIMPA;
`ifdef ARBITRO_WATCHDOG_EN
               erro_d  = 1'b0;
`endif
            end
         end
         LIMPA: begin
            // VGA cycles stall the clear counter.
            if (!vga_ativo) begin
               if (cnt_q == ULTIMO) begin
                  cnt_d   = '0;
                  state_d = INICIA;
                  start_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         INICIA: begin
            state_d = EXECUTA;
`ifdef ARBITRO_WATCHDOG_EN
            wdog_d  = '0;
`endif
         end
         EXECUTA: begin
            if (cpu_done) begin
               state_d = OCIOSO;
`ifdef ARBITRO_WATCHDOG_EN
            end else if (wdog_inc_c == WDOG_W'(WDOG_CICLOS - 1)) begin
               // Abort once the counter reaches the limit.
               erro_d  = 1'b1;
               state_d = OCIOSO;
            end else begin
               wdog_d  = wdog_inc_c;
`endif
            end
         end
         default: state_d = OCIOSO;
      endcase
      ocupado_d = (state_d != OCIOSO);
   end

   assign cpu_ack_c = (state_q == EXECUTA) & cpu_wr_req & ~vga_ativo;

   // Framebuffer port mux; the VGA read path has priority.
   always_comb begin
      mem_addr = vga_addr;
      mem_data = '0;
      mem_wren = 1'b0;
      if (state_q == LIMPA && !vga_ativo) begin
         mem_addr = cnt_q;
         mem_data = COR_FUNDO;
         mem_wren = 1'b1;
      end else if (cpu_ack_c) begin
         mem_addr = cpu_wr_addr;
         mem_data = cpu_wr_data;
         mem_wren = 1'b1;
      end
   end

   assign cpu_wr_ack      = cpu_ack_c;
   assign cpu_start       = start_q;
   assign cpu_modo        = modo_q;
   assign sistema_ocupado = ocupado_q;
`ifdef ARBITRO_WATCHDOG_EN
   assign erro = erro_q;
`else
   assign erro = 1'b0;
`endif

endmodule

// File: doc/arbitro_quadro.md
Name: arbitro_quadro

Overview:
- Sequences one "apply" job on the display framebuffer (640x480, 8-bit pixels) and shares that framebuffer between the VGA scan-out read path and the scaling CPU's write path.
- On a button press it latches the algorithm switches, clears the framebuffer, starts the CPU, and then grants CPU writes only while the VGA is not in the active display area.
- Sits between uc/cpu and the framebuffer memory, in the 25 MHz domain.

Parameters:
- FB_WORDS, 307200: framebuffer depth in words (640*480).
- ADDR_W, 19: framebuffer address width.
- DATA_W, 8: pixel width.
- COR_FUNDO, 8'h00: pixel value written during the clear phase.
- WDOG_CICLOS, 10000000: watchdog limit in cycles (only used with the optional feature).

Ports:
- clock  in  1  25 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- botao_aplicar  in  1  raw active-low pushbutton, asynchronous to clock.
- chaves  in  3  algorithm select.
- vga_ativo  in  1  high while the VGA needs a framebuffer read this cycle.
- vga_addr  in  ADDR_W  VGA read address.
- cpu_wr_req  in  1  CPU write request.
- cpu_wr_addr  in  ADDR_W  CPU write address.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_wr_ack  out  1  write accepted this cycle.
- cpu_done  in  1  CPU job-complete pulse.
- cpu_start  out  1  one-cycle start pulse.
- cpu_modo  out  3  latched chaves value.
- mem_addr  out  ADDR_W  framebuffer address.
- mem_data  out  DATA_W  framebuffer write data.
- mem_wren  out  1  framebuffer write enable.
- sistema_ocupado  out  1  high in any state other than OCIOSO.
- erro  out  1  watchdog abort flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State OCIOSO.
  - cpu_start=0, cpu_modo=0, cpu_wr_ack=0, sistema_ocupado=0, erro=0.
  - Clear counter=0, synchronizer flops=1 (button released).
- Button input:
  - Two-flop synchronizer, then falling-edge detect.
  - Produces one pulse per press; no debounce (handled upstream).
- States:
  - OCIOSO: on a press pulse, latch cpu_modo<=chaves and clear erro, then go to LIMPA. Presses in any other state are ignored.
  - LIMPA: on each cycle with vga_ativo=0, write COR_FUNDO at the counter address and increment the counter. After the write at FB_WORDS-1, reset the counter to 0 and go to INICIA. Cycles with vga_ativo=1 stall the counter.
  - INICIA: cpu_start=1 for exactly this one cycle, then go to EXECUTA.
  - EXECUTA: cpu_wr_ack = cpu_wr_req & ~vga_ativo (combinational). On cpu_done=1, go to OCIOSO next cycle. A write requested in the same cycle as cpu_done is still acked if vga_ativo=0.
- Memory mux (combinational):
  - In LIMPA with vga_ativo=0: addr = counter, data = COR_FUNDO, wren=1.
  - In EXECUTA with cpu_wr_ack=1: addr = cpu_wr_addr, data = cpu_wr_data, wren=1.
  - Otherwise: addr = vga_addr, data = 0, wren=0.
  - VGA always has priority. Memory read latency is the memory's own; this block adds none.
- Other rules:
  - cpu_done outside EXECUTA is ignored.
  - cpu_wr_req outside EXECUTA is never acked.
  - chaves changes after the latch do not affect cpu_modo.
  - Reset mid-job aborts immediately: counter returns to 0 and no further writes occur.
  - sistema_ocupado is registered from state: 1 in LIMPA, INICIA and EXECUTA.

Optional Feature:
- Macro: ARBITRO_WATCHDOG_EN.
- With the macro defined:
  - A 24-bit counter resets to 0 on entry to EXECUTA and increments each cycle there.
  - If it reaches WDOG_CICLOS-1 without cpu_done, the block sets erro=1 and returns to OCIOSO.
  - erro holds until the next accepted press or reset.
- Without the macro: no counter, erro tied to 0, and EXECUTA waits indefinitely.

Test Plan:
- Test parameters: FB_WORDS=16.
- Reset then press with vga_ativo=0, chaves=3'b101 -> cpu_modo=5; mem_wren high 16 consecutive cycles, addresses 0..15, data 8'h00; then exactly one cpu_start cycle; sistema_ocupado=1 throughout.
- Clear with vga_ativo toggling 1,0 every cycle -> 16 writes over 32 cycles, no address skipped or repeated, mem_addr=vga_addr on the vga_ativo=1 cycles.
- EXECUTA with cpu_wr_req=1, addr 19'h12345, data 8'hAB, and vga_ativo=1 for 3 cycles then 0 -> ack=0 for 3 cycles, then ack=1 with mem_addr=19'h12345, mem_data=8'hAB, mem_wren=1.
- Press during EXECUTA and chaves change -> no restart, cpu_modo unchanged; cpu_done -> OCIOSO next cycle, sistema_ocupado=0.
- Reset asserted at clear address 7 -> outputs at reset values immediately; a following press restarts the clear at address 0.
- With ARBITRO_WATCHDOG_EN and WDOG_CICLOS=50: no cpu_done -> erro=1 and OCIOSO 50 cycles after INICIA; the next press clears erro.
